// File: rtl/ram256_rr_arbiter.sv
// ram256_rr_arbiter
//   Shares one single-port RAM_256x32 (no byte enables) between two bus masters
//   using round-robin arbitration. One command is latched per grant. Writes with
//   partial byte enables become an internal read-modify-write.
//
// Ports
//   CLK, RST_n                 clock, synchronous active-low reset
//   req/wr/be/addr/wdata 0,1   requester command fields (valid while req high)
//   gnt0, gnt1                 command accepted (high during ACC)
//   done0, done1               access complete (high during RESP)
//   rdata0, rdata1             read data, valid with done, held until next read
//   ram_WR, ram_addr, ram_Din  RAM write enable / address / write data
//   ram_Dout                   RAM read data (combinational from ram_addr)
//   busy                       high whenever the FSM is not idle
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// ACC   | RAM accessed with the latched command (read, full write or merge read)
// MRG   | partial write: merged word written back
// RESP  | done pulse to the owning port; requests are not sampled
module ram256_rr_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32,
  localparam int NB = DW / 8
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          req0,
  input  logic          wr0,
  input  logic [NB-1:0] be0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [NB-1:0] be1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
  output logic          ram_WR,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_Din,
  input  logic [DW-1:0] ram_Dout,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_MRG  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]    state;
  logic          port_q;
  logic          wr_q;
  logic [NB-1:0] be_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] merge_q;
  // 1 when port 1 wins the next simultaneous request
  logic          prefer1;

  logic          sel;
  logic          full_be;
  logic          zero_be;
  logic [DW-1:0] merged;

  assign sel     = (req0 && req1) ? prefer1 : req1;
  assign full_be = &be_q;
  assign zero_be = ~|be_q;

  always_comb begin
    merged = merge_q;
    for (int i = 0; i < NB; i++) begin
      if (be_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state   <= ST_IDLE;
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      prefer1 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            port_q  <= sel;
            wr_q    <= sel ? wr1    : wr0;
            be_q    <= sel ? be1    : be0;
            addr_q  <= sel ? addr1  : addr0;
            wdata_q <= sel ? wdata1 : wdata0;
            prefer1 <= ~sel;
            state   <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (!wr_q) begin
            if (port_q) rdata1 <= ram_Dout;
            else        rdata0 <= ram_Dout;
            state <= ST_RESP;
          end else if (full_be || zero_be) begin
            // full write happens this cycle; be=0 completes as a no-op
            state <= ST_RESP;
          end else begin
            merge_q <= ram_Dout;
            state   <= ST_MRG;
          end
        end
        ST_MRG:  state <= ST_RESP;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_WR  = 1'b0;
    ram_Din = '0;
    if (state == ST_ACC && wr_q && full_be) begin
      ram_WR  = 1'b1;
      ram_Din = wdata_q;
    end else if (state == ST_MRG) begin
      ram_WR  = 1'b1;
      ram_Din = merged;
    end
  end

  assign ram_addr = addr_q;
  assign gnt0     = (state == ST_ACC)  && !port_q;
  assign gnt1     = (state == ST_ACC)  &&  port_q;
  assign done0    = (state == ST_RESP) && !port_q;
  assign done1    = (state == ST_RESP) &&  port_q;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ram256_rr_arbiter.sv
// Bench for ram256_rr_arbiter: behavioural RAM_256x32, reference memory and
// per-port scoreboards of expected read data popped on each done pulse.
module tb_ram256_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [3:0]  be0 = '0, be1 = '0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, ram_WR, busy;
  logic [31:0] rdata0, rdata1, ram_Din, ram_Dout;
  logic [7:0]  ram_addr;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          wr_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] eh0 = '0, eh1 = '0;   // expected held rdata at issue time
  logic [31:0] mh0 = '0, mh1 = '0;   // expected held rdata as seen by monitor
  logic [31:0] e0, e1;

  ram256_rr_arbiter dut (
    .CLK(CLK), .RST_n(RST_n),
    .req0(req0), .wr0(wr0), .be0(be0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .ram_WR(ram_WR), .ram_addr(ram_addr), .ram_Din(ram_Din), .ram_Dout(ram_Dout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  assign ram_Dout = mem[ram_addr];
  always @(posedge CLK) begin
    if (ram_WR === 1'b1) begin
      mem[ram_addr] <= ram_Din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  always @(negedge CLK) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) chk("spurious_done0", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("rdata0", rdata0, e0);
        mh0 = e0;
        chk("rdata1_idle", rdata1, mh1);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("spurious_done1", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("rdata1", rdata1, e1);
        mh1 = e1;
        chk("rdata0_idle", rdata0, mh0);
      end
    end
  end

  task automatic issue(input bit p, input bit w, input logic [3:0] b,
                       input logic [7:0] a, input logic [31:0] d);
    logic [31:0] x;
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
      x = p ? eh1 : eh0;
    end else begin
      x = ref_mem[a];
      if (p) eh1 = x; else eh0 = x;
    end
    if (p) q1.push_back(x); else q0.push_back(x);
  endtask

  task automatic drive(input bit p, input bit w, input logic [3:0] b,
                       input logic [7:0] a, input logic [31:0] d);
    if (p) begin req1 = 1; wr1 = w; be1 = b; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; wr0 = w; be0 = b; addr0 = a; wdata0 = d; end
  endtask

  task automatic access(input bit p, input bit w, input logic [3:0] b,
                        input logic [7:0] a, input logic [31:0] d,
                        input int lat, input string tag);
    int cyc = 0;
    bit fin = 0;
    @(negedge CLK);
    issue(p, w, b, a, d);
    drive(p, w, b, a, d);
    while (!fin && cyc < 12) begin
      @(negedge CLK);
      cyc++;
      if ((p ? gnt1 : gnt0) === 1'b1) begin
        if (p) req1 = 0; else req0 = 0;
      end
      if ((p ? done1 : done0) === 1'b1) fin = 1;
    end
    req0 = 0; req1 = 0;
    chk(tag, 32'(cyc), 32'(lat));
  endtask

  // both ports request reads together for n accesses; grants must go 0,1,0,1...
  task automatic both_req(input int n, input logic [7:0] a0, input logic [7:0] a1,
                          input string tag);
    bit order [$];
    int cyc = 0;
    @(negedge CLK);
    for (int i = 0; i < n; i++) issue(i[0], 1'b0, 4'hF, i[0] ? a1 : a0, 32'h0);
    drive(1'b0, 1'b0, 4'hF, a0, 32'h0);
    drive(1'b1, 1'b0, 4'hF, a1, 32'h0);
    while (order.size() < n && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (gnt0 === 1'b1) order.push_back(1'b0);
      if (gnt1 === 1'b1) order.push_back(1'b1);
      if (order.size() >= n) begin req0 = 0; req1 = 0; end
    end
    req0 = 0; req1 = 0;
    chk({tag, "_ngnt"}, 32'(order.size()), 32'(n));
    for (int i = 0; i < n && i < order.size(); i++)
      chk({tag, "_gnt_order"}, 32'(order[i]), 32'(i % 2));
    cyc = 0;
    while ((q0.size() + q1.size()) != 0 && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    chk({tag, "_drain"}, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int cyc;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // 1: reset with both requests high
    req0 = 1; req1 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_ctl", 32'({gnt0, gnt1, done0, done1, ram_WR, busy}), 32'd0);
      chk("rst_rdata", rdata0 | rdata1, 32'd0);
      chk("rst_ram", 32'(ram_addr) | ram_Din, 32'd0);
    end
    req0 = 0; req1 = 0;
    RST_n = 1;
    chk("rst_nowr", 32'(wr_cnt), 32'd0);

    // 2: full write then read on port 0
    wc = wr_cnt;
    access(0, 1, 4'hF, 8'h05, 32'hDEADBEEF, 2, "t2_wr_lat");
    access(0, 0, 4'hF, 8'h05, 32'h0, 2, "t2_rd_lat");
    chk("t2_wr_cycles", 32'(wr_cnt - wc), 32'd1);

    // 3: partial write via read-modify-write on port 1
    access(0, 1, 4'hF, 8'h10, 32'hAABBCCDD, 2, "t3_pre_lat");
    wc = wr_cnt;
    access(1, 1, 4'b0010, 8'h10, 32'h00001100, 3, "t3_lat");
    chk("t3_wr_cycles", 32'(wr_cnt - wc), 32'd1);
    chk("t3_mem", mem[8'h10], 32'hAABB11DD);
    access(1, 0, 4'hF, 8'h10, 32'h0, 2, "t3_rd_lat");

    // 4: both held for four accesses
    both_req(4, 8'h05, 8'h10, "t4");

    // 5: be=0 write is a no-op
    access(0, 1, 4'hF, 8'h20, 32'h12345678, 2, "t5_pre_lat");
    wc = wr_cnt;
    access(1, 1, 4'h0, 8'h20, 32'hFFFFFFFF, 2, "t5_lat");
    chk("t5_wr_cycles", 32'(wr_cnt - wc), 32'd0);
    access(1, 0, 4'hF, 8'h20, 32'h0, 2, "t5_rd_lat");

    // 6: reset during ACC of a partial write
    access(0, 1, 4'hF, 8'h30, 32'h55667788, 2, "t6_pre_lat");
    @(negedge CLK);
    drive(0, 1, 4'b0001, 8'h30, 32'hFFFFFFFF);
    cyc = 0;
    while (gnt0 !== 1'b1 && cyc < 10) begin @(negedge CLK); cyc++; end
    chk("t6_gnt", 32'(gnt0), 32'd1);
    req0 = 0;
    RST_n = 0;
    wc = wr_cnt;
    eh0 = '0; eh1 = '0; mh0 = '0; mh1 = '0;
    @(negedge CLK);
    RST_n = 1;
    chk("t6_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge CLK);
    chk("t6_nowr", 32'(wr_cnt - wc), 32'd0);
    chk("t6_mem", mem[8'h30], 32'h55667788);
    both_req(2, 8'h30, 8'h10, "t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
